shared_ram_rr: RTL and testbench
================================

// Module: shared_ram_rr
// PURPOSE
//   Single-port synchronous RAM shared by CORES requesters through a round-robin
//   arbiter. Generalises the single-master RAM: parametrised requester count,
//   per-core request/grant handshake, registered read data with per-core valid.
//   Sits between the processor cores and the shared data memory.
// PARAMETERS
//   DATA_WIDTH  12               word width in bits
//   DEPTH       256              number of words
//   ADDR_WIDTH  $clog2(DEPTH)    address width
//   CORES       4                number of requesters (>=1)
// PORTS
//   clk      in   1                      system clock, all state on posedge
//   rstN     in   1                      synchronous active-low reset
//   req      in   CORES                  req[i]=1: core i requests an access
//   wrEn     in   CORES                  wrEn[i]=1 write, 0 read (valid with req[i])
//   address  in   CORES*ADDR_WIDTH       core i address = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
//   dataIn   in   CORES*DATA_WIDTH       core i write data = bits [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt      out  CORES                  one-hot combinational grant, this cycle
//   dataOut  out  DATA_WIDTH             registered read data, shared by all cores
//   rdValid  out  CORES                  rdValid[i]=1: dataOut holds core i read result
// BEHAVIOUR
//   Reset (rstN=0 at posedge): rr pointer <= 0, dataOut <= 0, rdValid <= 0.
//     Memory contents are not cleared. While rstN=0, gnt = 0 and no write occurs.
//   Arbitration (combinational):
//     - Search req starting at index ptr, wrapping ptr..CORES-1, 0..ptr-1.
//     - First set bit k -> gnt = 1<<k; no req -> gnt = 0.
//     - At most one gnt bit set, ever.
//   Pointer update: on posedge with gnt[k]=1, ptr <= (k+1) mod CORES.
//     With no grant, ptr holds. CORES=1: gnt = req, ptr stays 0.
//   Handshake: core holds req/wrEn/address/dataIn stable until it samples gnt=1
//     at a posedge; the access completes at that edge. Dropping req before the
//     grant is legal and discards the request.
//   Write: posedge with gnt[k] & wrEn[k] -> mem[addr_k] <= data_k.
//     rdValid <= 0 and dataOut holds its previous value.
//   Read: posedge with gnt[k] & ~wrEn[k] -> dataOut <= mem[addr_k] (old contents),
//     rdValid <= 1<<k. Latency: 1 cycle from the granting edge.
//   Idle cycle (gnt=0): rdValid <= 0, dataOut holds.
//   rdValid is a single-cycle pulse per read. Back-to-back reads from different
//     cores give consecutive pulses on different bits.
//   Read-after-write (next grant, same address) returns the newly written word.
//   Reset mid-operation: a read granted at the same edge as rstN=0 is dropped
//     (no rdValid pulse). A pending req is re-arbitrated from ptr=0 after reset.
//   Addresses >= DEPTH (non-power-of-2 DEPTH):
//     - write is ignored;
//     - read returns 0 with rdValid asserted.
// TESTING
//   1 Reset: rstN=0 for 2 cycles with req=4'b1111 -> gnt=0, rdValid=0, dataOut=0.
//   2 Single core: core2 writes 12'h064 to addr 3, then reads addr 3
//     -> gnt=4'b0100 each cycle; rdValid=4'b0100 and dataOut=12'h064
//     one cycle after the read grant.
//   3 Fairness: req=4'b1111 held for 8 cycles after reset
//     -> gnt sequence 0001,0010,0100,1000,0001,...; each core granted exactly twice.
//   4 Wrap/skip: ptr=3, req=4'b0101
//     -> gnt=0001, then ptr=1 -> gnt=0100, then gnt=0001.
//   5 Contention RAW: core0 writes 12'hABC to addr 7 while core1 reads addr 7
//     in the same cycle -> core0 granted first; core1 read returns 12'hABC
//     with rdValid=4'b0010.
//   6 Random: 500 cycles of random req/wrEn/address/dataIn against a behavioural
//     model checked at each rdValid; 0 mismatches, never more than one gnt bit.

Source files
------------

// File: rtl/shared_ram_rr.sv
// shared_ram_rr: single-port synchronous RAM shared by CORES requesters.
// A round-robin arbiter picks one requester per cycle. The winner's access
// completes at the next posedge. Read data is registered, and rdValid flags
// which core the current dataOut belongs to.
//
// Handshake: core i drives req[i] together with wrEn[i], its address slice and
// its dataIn slice, and holds them stable. gnt[i] is a combinational
// acknowledge. The access is taken at the first posedge where req[i] and
// gnt[i] are both high. Dropping req[i] before that edge withdraws the request.
// At most one gnt bit is ever set.
module shared_ram_rr #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CORES      = 4
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic [CORES-1:0]              req,
    input  logic [CORES-1:0]              wrEn,
    input  logic [CORES*ADDR_WIDTH-1:0]   address,
    input  logic [CORES*DATA_WIDTH-1:0]   dataIn,
    output logic [CORES-1:0]              gnt,
    output logic [DATA_WIDTH-1:0]         dataOut,
    output logic [CORES-1:0]              rdValid
);

    localparam int PTR_W = (CORES > 1) ? $clog2(CORES) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      nextPtr;
    logic [PTR_W-1:0]      gntIdx;
    logic [PTR_W-1:0]      cand;
    logic [PTR_W:0]        sum;
    logic                  gntValid;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [DATA_WIDTH-1:0] selData;
    logic                  selWr;
    logic                  addrOk;

    // Round-robin search: scan ptr, ptr+1, ... wrapping modulo CORES; first requester wins.
    always_comb begin
        gntValid = 1'b0;
        gntIdx   = '0;
        cand     = '0;
        sum      = '0;
        if (rstN) begin
            for (int off = 0; off < CORES; off++) begin
                sum = {1'b0, ptr} + (PTR_W+1)'(off);
                if (sum >= (PTR_W+1)'(CORES)) begin
                    sum = sum - (PTR_W+1)'(CORES);
                end
                cand = sum[PTR_W-1:0];
                if (!gntValid && req[cand]) begin
                    gntValid = 1'b1;
                    gntIdx   = cand;
                end
            end
        end
    end

    // One-hot grant vector built from the winning index.
    always_comb begin
        gnt = '0;
        if (gntValid) begin
            gnt[gntIdx] = 1'b1;
        end
    end

    // Route the winner's access fields to the single memory port.
    assign selAddr = address[gntIdx*ADDR_WIDTH +: ADDR_WIDTH];
    assign selData = dataIn[gntIdx*DATA_WIDTH +: DATA_WIDTH];
    assign selWr   = wrEn[gntIdx];
    // Only matters when DEPTH is not a power of two.
    assign addrOk  = (32'(selAddr) < DEPTH);
    assign nextPtr = (gntIdx == PTR_W'(CORES-1)) ? '0 : gntIdx + 1'b1;

    // Pointer moves past the core just served; holds when nobody is granted.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            ptr <= '0;
        end else if (gntValid) begin
            ptr <= nextPtr;
        end
    end

    // Memory write port; out-of-range writes are dropped. gnt is 0 in reset.
    always_ff @(posedge clk) begin
        if (gntValid && selWr && addrOk) begin
            mem[selAddr] <= selData;
        end
    end

    // Registered read: dataOut holds across writes and idle cycles; rdValid pulses per read.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            dataOut <= '0;
            rdValid <= '0;
        end else begin
            rdValid <= '0;
            if (gntValid && !selWr) begin
                dataOut <= addrOk ? mem[selAddr] : '0;
                rdValid <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_shared_ram_rr.sv
// Bench for shared_ram_rr: directed scenarios with literal expectations plus
// a randomized run. A behavioural model follows the DUT cycle by cycle.
module tb_shared_ram_rr;

    localparam int DW    = 12;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int CORES = 4;

    logic                clk = 1'b0;
    logic                rstN;
    logic [CORES-1:0]    req;
    logic [CORES-1:0]    wrEn;
    logic [CORES*AW-1:0] address;
    logic [CORES*DW-1:0] dataIn;
    logic [CORES-1:0]    gnt;
    logic [DW-1:0]       dataOut;
    logic [CORES-1:0]    rdValid;

    int nChecks = 0;
    int nErr    = 0;

    // behavioural model state
    int            mPtr;
    logic [DW-1:0] mDataOut;
    logic [3:0]    mRdValid;
    bit            mKnown = 1'b0;
    bit            modelOn = 1'b0;
    logic [DW-1:0] mMem [DEPTH];
    bit            mWritten [DEPTH];

    shared_ram_rr #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CORES(CORES)
    ) dut (
        .clk(clk), .rstN(rstN), .req(req), .wrEn(wrEn), .address(address),
        .dataIn(dataIn), .gnt(gnt), .dataOut(dataOut), .rdValid(rdValid)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setCore(input int i, input logic w, input int a, input int d);
        wrEn[i]              = w;
        address[i*AW +: AW]  = AW'(a);
        dataIn[i*DW +: DW]   = DW'(d);
    endtask

    // Grant rule: first requester found scanning from ptr upward, wrapping.
    function automatic logic [3:0] modelGnt(input logic [3:0] r, input int p, input logic rst);
        if (!rst) return 4'b0000;
        for (int j = 0; j < CORES; j++) begin
            int c;
            c = (p + j) % CORES;
            if (r[c]) return 4'(1 << c);
        end
        return 4'b0000;
    endfunction

    // model: advance on every posedge using the inputs that edge samples
    always @(posedge clk) begin
        logic [3:0] g;
        int k;
        int a;
        if (!rstN) begin
            mPtr = 0; mDataOut = '0; mRdValid = '0; mKnown = 1'b1; modelOn = 1'b1;
        end else if (modelOn) begin
            g = modelGnt(req, mPtr, rstN);
            mRdValid = '0;
            if (g != 0) begin
                k = $clog2(g);
                a = int'(address[k*AW +: AW]);
                if (wrEn[k]) begin
                    if (a < DEPTH) begin
                        mMem[a] = dataIn[k*DW +: DW];
                        mWritten[a] = 1'b1;
                    end
                end else begin
                    if (a < DEPTH) begin
                        mDataOut = mMem[a];
                        mKnown   = mWritten[a];
                    end else begin
                        mDataOut = '0;
                        mKnown   = 1'b1;
                    end
                    mRdValid = g;
                end
                mPtr = (k + 1) % CORES;
            end
        end
    end

    // scoreboard compare: every negedge once the model is synchronised
    always @(negedge clk) begin
        if (modelOn) begin
            chk("gnt", 32'(gnt), 32'(modelGnt(req, mPtr, rstN)));
            nChecks++;
            if ($countones(gnt) > 1) begin
                nErr++;
                $display("FAIL gnt_onehot: got %b, expected at most one bit set", gnt);
            end
            chk("rdValid", 32'(rdValid), 32'(mRdValid));
            if (mKnown) chk("dataOut", 32'(dataOut), 32'(mDataOut));
        end
    end

    // driver / directed + random stimulus
    initial begin
        int cnt [CORES];
        bit pending [CORES];
        logic pWr [CORES];
        int pAddr [CORES];
        int pData [CORES];
        logic [3:0] gSeen;

        rstN = 1'b0; req = 4'b1111; wrEn = '0; address = '0; dataIn = '0;

        // reset with all requests raised
        tick();
        chk("rst1_gnt", 32'(gnt), 32'h0);
        chk("rst1_rdValid", 32'(rdValid), 32'h0);
        chk("rst1_dataOut", 32'(dataOut), 32'h0);
        tick();
        chk("rst2_gnt", 32'(gnt), 32'h0);
        chk("rst2_rdValid", 32'(rdValid), 32'h0);
        chk("rst2_dataOut", 32'(dataOut), 32'h0);
        rstN = 1'b1; req = '0;
        tick();

        // single core write then read
        req = 4'b0100; setCore(2, 1'b1, 3, 12'h064);
        #1 chk("t2_wr_gnt", 32'(gnt), 32'h4);
        tick();
        wrEn[2] = 1'b0;
        #1 chk("t2_rd_gnt", 32'(gnt), 32'h4);
        tick();
        chk("t2_rdValid", 32'(rdValid), 32'h4);
        chk("t2_dataOut", 32'(dataOut), 32'h064);
        req = '0;
        tick();
        chk("t2_pulse_end", 32'(rdValid), 32'h0);

        // fairness: all four request for 8 cycles straight after reset
        rstN = 1'b0;
        tick();
        rstN = 1'b1; req = 4'b1111;
        for (int i = 0; i < CORES; i++) begin
            setCore(i, 1'b0, 3, 0);
            cnt[i] = 0;
        end
        for (int c = 0; c < 8; c++) begin
            #1 chk("t3_gnt", 32'(gnt), 32'(1 << (c % 4)));
            for (int i = 0; i < CORES; i++) if (gnt[i]) cnt[i]++;
            tick();
        end
        for (int i = 0; i < CORES; i++) chk("t3_count", 32'(cnt[i]), 32'd2);
        req = '0;

        // wrap/skip: steer ptr to 3, then two requesters 0 and 2
        req = 4'b0100;
        tick();
        req = 4'b0101;
        #1 chk("t4_gnt_a", 32'(gnt), 32'h1);
        tick();
        #1 chk("t4_gnt_b", 32'(gnt), 32'h4);
        tick();
        #1 chk("t4_gnt_c", 32'(gnt), 32'h1);
        tick();
        req = '0;
        tick();

        // contention RAW: core0 writes addr 7 while core1 reads addr 7
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        setCore(0, 1'b1, 7, 12'hABC);
        setCore(1, 1'b0, 7, 0);
        req = 4'b0011;
        #1 chk("t5_first_gnt", 32'(gnt), 32'h1);
        tick();
        req = 4'b0010;
        #1 chk("t5_second_gnt", 32'(gnt), 32'h2);
        tick();
        chk("t5_rdValid", 32'(rdValid), 32'h2);
        chk("t5_dataOut", 32'(dataOut), 32'hABC);
        req = '0;
        tick();

        // random traffic obeying the hold-until-granted protocol
        for (int i = 0; i < CORES; i++) begin
            pending[i] = 1'b0; pWr[i] = 1'b0; pAddr[i] = 0; pData[i] = 0;
        end
        for (int cyc = 0; cyc < 500; cyc++) begin
            rstN = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < CORES; i++) begin
                if (pending[i] && $urandom_range(0, 19) == 0) pending[i] = 1'b0;
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    pending[i] = 1'b1;
                    pWr[i]     = 1'($urandom_range(0, 1));
                    pAddr[i]   = $urandom_range(0, 15);
                    pData[i]   = $urandom_range(0, 4095);
                end
                req[i] = pending[i];
                setCore(i, pWr[i], pAddr[i], pData[i]);
            end
            #1 gSeen = gnt;
            tick();
            for (int i = 0; i < CORES; i++) if (gSeen[i]) pending[i] = 1'b0;
        end
        rstN = 1'b1; req = '0;
        tick();
        tick();

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErr);
        $finish;
    end

endmodule
